uart_frame_rx: RTL and testbench

- Parametrised successor to the team's multi-byte UART receiver.
- Instantiates the existing UART_RX byte receiver and runs a framer state machine on its output.
- Frames are delimited by a start byte (SOF) and an end byte (EOF), carry a variable-length payload and an optional 8-bit additive checksum, and are aborted by an inter-byte timeout.
- Delivers one registered, length-tagged frame per valid packet to the command decoder, plus error pulses for malformed frames.

---
 rtl/uart_frame_rx.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// UART frame receiver: an 8N1 byte receiver feeding a SOF/EOF framer with optional
// additive checksum, overflow detection and inter-byte timeout.

module UART_RX #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UARTBaud = 115200
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       uartrx,
  output logic       uart_rx_done,
  output logic [7:0] odat
);
  localparam int BIT_CLKS = CLK_FREQ / UARTBaud;
  localparam int CW       = $clog2(BIT_CLKS + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e state_q, state_d;

  logic [1:0]    sync_q;
  logic          rx_s, bit_end, half_end;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, odat_q, odat_d;
  logic          done_q, done_d;

  assign rx_s     = sync_q[1];
  assign bit_end  = (cnt_q == CW'(BIT_CLKS - 1));
  assign half_end = (cnt_q == CW'(BIT_CLKS / 2 - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      odat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], uartrx};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      odat_q  <= odat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (!rx_s) state_d = RX_START;
      RX_START: if (half_end) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (bit_end) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Start bit is qualified at its midpoint, so every later sample lands mid-bit.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == RX_IDLE || (state_q == RX_START && half_end) || bit_end) cnt_d = '0;
    if (state_q == RX_DATA && bit_end) begin
      shift_d = {rx_s, shift_q[7:1]};
      bit_d   = bit_q + 1'b1;
    end
    done_d = (state_q == RX_STOP) && bit_end && rx_s;
    odat_d = done_d ? shift_q : odat_q;
  end

  assign uart_rx_done = done_q;
  assign odat         = odat_q;
endmodule

module uart_frame_rx #(
  parameter int         CLK_FREQ      = 50_000_000,
  parameter int         BAUD          = 115200,
  parameter int         MAX_BYTES     = 8,
  parameter logic [7:0] SOF           = 8'h73,
  parameter logic [7:0] EOF           = 8'h65,
  parameter int         CHECKSUM_EN   = 1,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   uartrx,
  output logic                   frame_valid,
  output logic [MAX_BYTES*8-1:0] frame_data,
  output logic [7:0]             frame_len,
  output logic                   frame_err,
  output logic [1:0]             err_code
);
  localparam int CAP      = MAX_BYTES + CHECKSUM_EN;
  localparam int DW       = MAX_BYTES * 8;
  localparam int TMO_CLKS = TIMEOUT_BYTES * (10 * CLK_FREQ / BAUD);
  localparam int TW       = $clog2(TMO_CLKS + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DISCARD} state_e;
  state_e state_q, state_d;

  logic           uart_rx_done;
  logic [7:0]     odat;
  logic [CAP*8-1:0] buf_q, buf_d, data_buf;
  logic [8:0]     wr_idx_q, wr_idx_d, ck_idx;
  logic [7:0]     sum_q, sum_d, ck_byte;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           valid_q, valid_d, err_q, err_d;
  logic [1:0]     code_q, code_d;
  logic [DW-1:0]  data_q, data_d;
  logic [7:0]     len_q, len_d;
  logic           is_sof, is_eof, is_data, full, tmo_hit, ck_ok;

  UART_RX #(.CLK_FREQ(CLK_FREQ), .UARTBaud(BAUD)) u_rx (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .uartrx       (uartrx),
    .uart_rx_done (uart_rx_done),
    .odat         (odat)
  );

  assign is_sof  = uart_rx_done && (odat == SOF);
  assign is_eof  = uart_rx_done && (odat == EOF);
  assign is_data = uart_rx_done && (odat != SOF) && (odat != EOF);
  assign full    = (wr_idx_q == 9'(CAP));
  // Fires one cycle early so frame_err lands exactly TMO_CLKS clocks after the last byte.
  assign tmo_hit = !uart_rx_done && (tmo_q == TW'(TMO_CLKS - 2));
  assign ck_idx  = (wr_idx_q == '0) ? '0 : wr_idx_q - 9'd1;
  assign ck_byte = buf_q[8*ck_idx +: 8];
  assign ck_ok   = (wr_idx_q != '0) && (8'(sum_q - ck_byte) == ck_byte);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (is_sof) state_d = PAYLOAD;
      PAYLOAD: begin
        if (is_eof)              state_d = IDLE;
        else if (is_data && full) state_d = DISCARD;
        else if (tmo_hit)         state_d = IDLE;
      end
      DISCARD: begin
        if (is_eof || tmo_hit) state_d = IDLE;
        else if (is_sof)       state_d = PAYLOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d    = buf_q;
    wr_idx_d = wr_idx_q;
    sum_d    = sum_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    data_d   = data_q;
    len_d    = len_q;
    data_buf = buf_q;
    tmo_d    = (uart_rx_done || tmo_hit || state_q == IDLE) ? '0 : tmo_q + 1'b1;
    if (is_sof) begin
      buf_d    = '0;
      wr_idx_d = '0;
      sum_d    = '0;
    end else if (state_q == PAYLOAD) begin
      if (is_data && full) begin
        err_d  = 1'b1;
        code_d = 2'b01;
      end else if (is_data) begin
        buf_d[8*wr_idx_q +: 8] = odat;
        wr_idx_d = wr_idx_q + 9'd1;
        sum_d    = sum_q + odat;
      end else if (is_eof) begin
        if (CHECKSUM_EN == 0) begin
          valid_d = 1'b1;
          data_d  = DW'(buf_q);
          len_d   = 8'(wr_idx_q);
        end else if (!ck_ok) begin
          err_d  = 1'b1;
          code_d = 2'b11;
        end else begin
          data_buf[8*ck_idx +: 8] = '0;
          valid_d = 1'b1;
          data_d  = DW'(data_buf);
          len_d   = 8'(ck_idx);
        end
      end else if (tmo_hit) begin
        err_d  = 1'b1;
        code_d = 2'b10;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      wr_idx_q <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      data_q   <= '0;
      len_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_idx_q <= wr_idx_d;
      sum_q    <= sum_d;
      tmo_q    <= tmo_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
      data_q   <= data_d;
      len_q    <= len_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign frame_data  = data_q;
  assign frame_len   = len_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: serial stimulus, byte-level frame model,
// and a monitor that pops expectations on every frame_valid/frame_err pulse.

module tb_uart_frame_rx;
  localparam int         CLK_FREQ = 1_000_000;
  localparam int         BAUD     = 100_000;
  localparam int         MAXB     = 8;
  localparam int         CK       = 1;
  localparam int         TOB      = 4;
  localparam int         BIT      = CLK_FREQ / BAUD;
  localparam int         TO_CLKS  = TOB * (10 * CLK_FREQ / BAUD);
  localparam int         CAP      = MAXB + CK;
  localparam logic [7:0] SOF      = 8'h73;
  localparam logic [7:0] EOF      = 8'h65;

  logic              sys_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              uartrx  = 1'b1;
  logic              frame_valid, frame_err;
  logic [MAXB*8-1:0] frame_data;
  logic [7:0]        frame_len;
  logic [1:0]        err_code;

  uart_frame_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_BYTES(MAXB), .SOF(SOF), .EOF(EOF),
    .CHECKSUM_EN(CK), .TIMEOUT_BYTES(TOB)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .uartrx(uartrx),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_len(frame_len),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit                is_err;
    logic [1:0]        code;
    int                len;
    logic [MAXB*8-1:0] data;
    bit                tmo;
  } exp_t;

  exp_t              expq[$];
  int                compared   = 0;
  int                mismatched = 0;
  int                mstate     = 0;   // 0 idle, 1 in frame, 2 discarding
  logic [7:0]        mbytes[$];
  int                hold_len   = 0;
  logic [MAXB*8-1:0] hold_data  = '0;

  function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push_err(logic [1:0] code, bit tmo);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.len = 0; e.data = '0; e.tmo = tmo;
    expq.push_back(e);
  endfunction

  function automatic void complete_frame();
    exp_t       e;
    int         n;
    logic [7:0] s;
    n = mbytes.size() - CK;
    if (n < 0) begin
      push_err(2'b11, 1'b0);
      return;
    end
    s = 8'h00;
    for (int i = 0; i < n; i++) s = s + mbytes[i];
    if (CK != 0 && s != mbytes[n]) begin
      push_err(2'b11, 1'b0);
      return;
    end
    e.is_err = 1'b0; e.code = 2'b00; e.len = n; e.data = '0; e.tmo = 1'b0;
    for (int i = 0; i < n; i++) e.data[8*i +: 8] = mbytes[i];
    expq.push_back(e);
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (b == SOF) begin
      mstate = 1;
      mbytes.delete();
    end else if (mstate == 1) begin
      if (b == EOF) begin
        complete_frame();
        mstate = 0;
      end else if (mbytes.size() == CAP) begin
        push_err(2'b01, 1'b0);
        mstate = 2;
      end else begin
        mbytes.push_back(b);
      end
    end else if (mstate == 2 && b == EOF) begin
      mstate = 0;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    uartrx = 1'b0;
    repeat (BIT) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uartrx = b[i];
      repeat (BIT) @(posedge sys_clk);
    end
    uartrx = 1'b1;
    repeat (BIT) @(posedge sys_clk);
  endtask

  task automatic gap_short();
    repeat ($urandom_range(0, BIT * 10)) @(posedge sys_clk);
  endtask

  task automatic gap_long();
    if (mstate == 1) push_err(2'b10, 1'b1);
    mstate = 0;
    repeat (TO_CLKS + 20 * BIT) @(posedge sys_clk);
  endtask

  task automatic send_seq(input logic [7:0] s[]);
    foreach (s[i]) begin
      send_byte(s[i]);
      gap_short();
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == SOF || b == EOF);
    return b;
  endfunction

  // Monitor: pulse checks use the cycle of the most recent byte-done as reference.
  int cyc       = 0;
  int last_done = 0;
  always @(posedge sys_clk) begin
    exp_t e;
    #1;
    cyc++;
    if (frame_valid || frame_err) begin
      check("valid/err exclusive", {127'b0, frame_valid & frame_err}, 128'd0);
      check("pending expectation", {127'b0, expq.size() > 0}, 128'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("pulse kind", {127'b0, frame_err}, {127'b0, e.is_err});
        check("latency", 128'(cyc - last_done), e.tmo ? 128'(TO_CLKS) : 128'd1);
        if (e.is_err) begin
          check("err_code", {126'b0, err_code}, {126'b0, e.code});
          check("len held on err", {120'b0, frame_len}, 128'(hold_len));
          check("data held on err", 128'(frame_data), 128'(hold_data));
        end else begin
          check("frame_len", {120'b0, frame_len}, 128'(e.len));
          check("frame_data", 128'(frame_data), 128'(e.data));
          hold_len  = e.len;
          hold_data = e.data;
        end
      end
    end
    if (dut.uart_rx_done) last_done = cyc;
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] s;
    int         n;
    repeat (5) @(posedge sys_clk);
    #1;
    check("reset frame_len", {120'b0, frame_len}, 128'd0);
    check("reset frame_data", 128'(frame_data), 128'd0);
    check("reset err_code", {126'b0, err_code}, 128'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);

    send_seq('{SOF, 8'h01, 8'h02, 8'h03, 8'h06, EOF});
    send_seq('{SOF, 8'h01, 8'h02, 8'h05, EOF});
    send_seq('{SOF, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, EOF});
    send_seq('{SOF, 8'hAA});
    gap_long();
    send_seq('{SOF, 8'h01, 8'h02, 8'h03, 8'h06, EOF});
    send_seq('{8'h41, 8'h65, SOF, 8'h11, SOF, 8'h00, EOF});
    send_seq('{SOF, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h2C, EOF});

    send_seq('{SOF, 8'h01, 8'h02});
    rst_n = 1'b0;
    mstate = 0;
    mbytes.delete();
    hold_len  = 0;
    hold_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst frame_len", {120'b0, frame_len}, 128'd0);
    check("rst frame_data", 128'(frame_data), 128'd0);
    check("rst err_code", {126'b0, err_code}, 128'd0);
    check("rst pulses", {126'b0, frame_valid, frame_err}, 128'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    send_seq('{SOF, 8'h21, 8'h22, 8'h43, EOF});

    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(0, 3) == 0) send_seq('{8'($urandom)});
      if (mstate != 0) send_seq('{EOF});
      pl.delete();
      n = $urandom_range(0, MAXB + 2);
      for (int i = 0; i < n; i++) pl.push_back(rnd_byte());
      s = 8'h00;
      foreach (pl[i]) s = s + pl[i];
      if ($urandom_range(0, 3) != 0) begin
        if (s == SOF || s == EOF) begin
          pl.push_back(8'h01);
          s = s + 8'h01;
        end
      end else begin
        logic [7:0] bad;
        do bad = rnd_byte(); while (bad == s);
        s = bad;
      end
      send_byte(SOF);
      gap_short();
      foreach (pl[i]) begin
        if ($urandom_range(0, 15) == 0) begin
          send_byte(SOF);
          gap_short();
        end
        send_byte(pl[i]);
        gap_short();
      end
      send_byte(s);
      if ($urandom_range(0, 5) == 0) gap_long();
      else gap_short();
      send_byte(EOF);
      gap_short();
    end

    repeat (50) @(posedge sys_clk);
    check("queue drained", 128'(expq.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
